run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 135 +++++++++++++
 tb/tb_run_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// rtl/run_controller.sv - debug run/step/breakpoint controller gating the CPU clock enable (optional BREAKPOINT_EN)
module run_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_req,
  input  logic                  step_req,
  input  logic                  halt_req,
  input  logic                  cpu_halt,
  input  logic                  instr_boundary,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  bp_we,
  input  logic                  bp_clr,
  input  logic [ADDR_WIDTH-1:0] bp_addr_in,
  input  logic                  cnt_clr,
  output logic                  cpu_ce,
  output logic [1:0]            state,
  output logic                  bp_hit,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_PAUSED = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic                 bp_hit_q, bp_hit_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bp_match;
  logic                 active;
  logic                 stop_now;

`ifdef BREAKPOINT_EN
  logic                  bp_valid_q;
  logic [ADDR_WIDTH-1:0] bp_addr_q;

  // Breakpoint register: a clear beats a write landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
    end else if (bp_clr) begin
      bp_valid_q <= 1'b0;
    end else if (bp_we) begin
      bp_valid_q <= 1'b1;
      bp_addr_q  <= bp_addr_in;
    end
  end

  assign bp_match = bp_valid_q && (pc == bp_addr_q);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{bp_we, bp_clr, bp_addr_in, pc};
  assign bp_match = 1'b0;
`endif

  // Stop decision and clock enable; reset also forces the enable low directly.
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_STEP);
    stop_now = armed_q && instr_boundary &&
               ((state_q == S_STEP) || ((state_q == S_RUN) && bp_match));
    cpu_ce   = reset && active && !stop_now && !cpu_halt && !halt_req;
  end

  // Next state with priority cpu_halt > halt_req > stop_now > run_req > step_req.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    bp_hit_d = 1'b0;
    case (state_q)
      S_PAUSED: begin
        if (run_req)       state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (!instr_boundary) armed_d = 1'b1;
        if (cpu_halt) begin
          state_d = S_HALTED;
        end else if (halt_req) begin
          state_d = S_PAUSED;
        end else if (stop_now) begin
          state_d  = S_PAUSED;
          bp_hit_d = (state_q == S_RUN);
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_HALTED;
    endcase
    // Entering RUN or STEP disarms so the resume instruction is never re-trapped.
    if ((state_d != state_q) && ((state_d == S_RUN) || (state_d == S_STEP)))
      armed_d = 1'b0;
  end

  // Executed-cycle counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (cpu_ce && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_PAUSED;
      armed_q  <= 1'b0;
      bp_hit_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      bp_hit_q <= bp_hit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state       = state_q;
  assign cycle_count = cnt_q;
`ifdef BREAKPOINT_EN
  assign bp_hit = bp_hit_q;
`else
  logic unused_bp_hit;
  assign unused_bp_hit = bp_hit_q;
  assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller
module tb_run_controller;
  localparam int AW = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PAUSED = 0, RUN = 1, STEP = 2, HALTED = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic          cpu_halt = 1'b0, instr_boundary = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          bp_we = 1'b0, bp_clr = 1'b0, cnt_clr = 1'b0;
  logic [AW-1:0] bp_addr_in = '0;
  logic          cpu_ce, bp_hit;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int vectors = 0;
  int errors  = 0;

  // reference model of the controller
  int            m_st;
  bit            m_armed, m_bphit, m_bpv;
  logic [AW-1:0] m_bpa;
  int            m_cnt;

  // toy CPU: 2 cycles per instruction, T0 = boundary
  bit env_on;
  int e_t, e_pc, e_a, ldi_pc, hlt_pc;
  bit e_halt;

  always #5 clk = ~clk;

  run_controller #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .cpu_halt(cpu_halt), .instr_boundary(instr_boundary),
    .pc(pc), .bp_we(bp_we), .bp_clr(bp_clr), .bp_addr_in(bp_addr_in),
    .cnt_clr(cnt_clr), .cpu_ce(cpu_ce), .state(state), .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stop();
`ifdef BREAKPOINT_EN
    bit bpm = m_bpv && (pc == m_bpa);
`else
    bit bpm = 1'b0;
`endif
    return m_armed && instr_boundary && (m_st == STEP || (m_st == RUN && bpm));
  endfunction

  function automatic bit m_ce();
    return (m_st == RUN || m_st == STEP) && !m_stop() && !cpu_halt && !halt_req;
  endfunction

  task automatic m_clock(input bit ce);
    int nxt = m_st;
    bit hit = 1'b0;
    bit stop = m_stop();
    if (m_st == RUN || m_st == STEP) begin
      if (cpu_halt) nxt = HALTED;
      else if (halt_req) nxt = PAUSED;
      else if (stop) begin nxt = PAUSED; hit = (m_st == RUN); end
      else if (run_req) nxt = RUN;
    end else if (m_st == PAUSED) begin
      if (run_req) nxt = RUN;
      else if (step_req) nxt = STEP;
    end
    if ((nxt == RUN || nxt == STEP) && nxt != m_st) m_armed = 1'b0;
    else if ((m_st == RUN || m_st == STEP) && !instr_boundary) m_armed = 1'b1;
    if (cnt_clr) m_cnt = 0;
    else if (ce) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
`ifdef BREAKPOINT_EN
    if (bp_clr) m_bpv = 1'b0;
    else if (bp_we) begin m_bpv = 1'b1; m_bpa = bp_addr_in; end
`endif
    m_bphit = hit;
    m_st = nxt;
  endtask

  task automatic env_clock(input bit ce);
    if (env_on && ce) begin
      if (e_t == 0) begin
        e_t = 1;
        if (e_pc == hlt_pc) e_halt = 1'b1;
      end else begin
        e_t = 0;
        if (e_pc == ldi_pc) e_a = 8;
        e_pc++;
      end
    end
  endtask

  task automatic env_drive();
    if (env_on) begin
      instr_boundary = (e_t == 0);
      pc = e_pc[AW-1:0];
      cpu_halt = e_halt;
    end
  endtask

  task automatic tick();
    bit ce;
    #1;
    ce = m_ce();
    chk("cpu_ce", {31'b0, cpu_ce}, {31'b0, ce});
    @(posedge clk);
    #1;
    m_clock(ce);
    env_clock(ce);
    chk("state", {30'b0, state}, m_st);
    chk("bp_hit", {31'b0, bp_hit}, {31'b0, m_bphit});
    chk("cycle_count", {28'b0, cycle_count}, m_cnt);
    run_req = 0; step_req = 0; halt_req = 0; bp_we = 0; bp_clr = 0; cnt_clr = 0;
    env_drive();
  endtask

  task automatic do_reset();
    run_req = 0; step_req = 0; halt_req = 0; bp_we = 0; bp_clr = 0; cnt_clr = 0;
    reset = 1'b0;
    #1;
    chk("async_cpu_ce", {31'b0, cpu_ce}, 0);
    chk("async_state", {30'b0, state}, PAUSED);
    m_st = PAUSED; m_armed = 0; m_bphit = 0; m_bpv = 0; m_bpa = '0; m_cnt = 0;
    e_t = 0; e_pc = 0; e_a = 0; e_halt = 0;
    env_drive();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    env_on = 1; ldi_pc = 0; hlt_pc = 1;

    // reset, idle: nothing moves
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("idle_state", {30'b0, state}, PAUSED);
      chk("idle_cnt", {28'b0, cycle_count}, 0);
    end

    // LDI A,#08 ; HLT
    run_req = 1; tick();
    chk("run_state", {30'b0, state}, RUN);
    repeat (4) tick();
    chk("hlt_state", {30'b0, state}, HALTED);
    chk("hlt_cnt", {28'b0, cycle_count}, 3);
    chk("hlt_a", e_a, 8);
    run_req = 1; tick();
    step_req = 1; tick();
    chk("halted_sticky", {30'b0, state}, HALTED);

    // mid-instruction reset while running
    do_reset();
    hlt_pc = -1;
    run_req = 1; tick();
    tick();
    do_reset();
    chk("post_reset_cnt", {28'b0, cycle_count}, 0);

    // three single steps
    for (int k = 0; k < 3; k++) begin
      step_req = 1; tick();
      chk("step_enter", {30'b0, state}, STEP);
      repeat (4) tick();
      chk("step_pause", {30'b0, state}, PAUSED);
      chk("step_pc", {16'b0, pc}, k + 1);
    end

    // breakpoint at 0x0004
    do_reset();
    bp_addr_in = 16'h0004; bp_we = 1; tick();
    run_req = 1; tick();
`ifdef BREAKPOINT_EN
    for (int i = 0; i < 30 && m_st != PAUSED; i++) tick();
    chk("bp_state", {30'b0, state}, PAUSED);
    chk("bp_pc", {16'b0, pc}, 4);
    chk("bp_hit_pulse", {31'b0, bp_hit}, 1);
    tick();
    chk("bp_hit_single", {31'b0, bp_hit}, 0);
    run_req = 1; tick();
    repeat (4) tick();
    chk("bp_no_retrap", {30'b0, state}, RUN);
    chk("bp_resume_pc", {16'b0, pc}, 6);
`else
    repeat (12) tick();
    chk("nobp_state", {30'b0, state}, RUN);
    chk("nobp_pc", {16'b0, pc}, 6);
`endif

    // halt_req with run_req, then cpu_halt with halt_req
    do_reset();
    run_req = 1; tick();
    repeat (3) tick();
    halt_req = 1; run_req = 1; tick();
    chk("halt_over_run", {30'b0, state}, PAUSED);
    run_req = 1; tick();
    e_halt = 1; cpu_halt = 1; halt_req = 1; tick();
    chk("cpuhalt_over_halt", {30'b0, state}, HALTED);

    // saturation and clear-vs-increment
    do_reset();
    run_req = 1; tick();
    repeat (20) tick();
    chk("cnt_sat", {28'b0, cycle_count}, CMAX);
    cnt_clr = 1; tick();
    chk("cnt_clr_wins", {28'b0, cycle_count}, 0);

    // randomized traffic against the model
    env_on = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      run_req        = ($urandom_range(7) == 0);
      step_req       = ($urandom_range(7) == 0);
      halt_req       = ($urandom_range(11) == 0);
      cnt_clr        = ($urandom_range(15) == 0);
      bp_we          = ($urandom_range(7) == 0);
      bp_clr         = ($urandom_range(15) == 0);
      bp_addr_in     = AW'($urandom_range(7));
      instr_boundary = $urandom_range(1) == 1;
      pc             = AW'($urandom_range(7));
      cpu_halt       = ($urandom_range(59) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
